id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_if.sv | 76 +++++++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, downstream forwarding sources,
// pipeline control and the EX-side outputs that feed the ALU and EX/MEM.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Pipeline control
    logic              hold;
    logic              flush;

    // Decoded instruction from ID
    logic              id_valid;
    logic [DATA_W-1:0] id_read_data_1;
    logic [DATA_W-1:0] id_read_data_2;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_shamt;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [1:0]        id_ALUOp;
    logic              id_ALUSrc;
    logic              id_RegDst;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_MemtoReg;
    logic              id_uses_rt;

    // Forwarding sources from later stages
    logic              exmem_RegWrite;
    logic [REG_W-1:0]  exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_RegWrite;
    logic [REG_W-1:0]  memwb_rd;
    logic [DATA_W-1:0] memwb_result;

    // EX-side outputs
    logic [DATA_W-1:0] operando_1;
    logic [DATA_W-1:0] operando_2;
    logic [1:0]        ALUOp;
    logic [5:0]        operation;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_write_reg;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_MemtoReg;
    logic              ex_valid;
    logic              load_use_hazard;

    // Upstream side: drives ID fields, control and forwarding sources
    modport master (
        output hold, flush,
        output id_valid, id_read_data_1, id_read_data_2, id_imm, id_shamt,
        output id_rs, id_rt, id_rd, id_ALUOp, id_ALUSrc, id_RegDst,
        output id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_uses_rt,
        output exmem_RegWrite, exmem_rd, exmem_result,
        output memwb_RegWrite, memwb_rd, memwb_result,
        input  operando_1, operando_2, ALUOp, operation, ex_store_data,
        input  ex_write_reg, ex_RegWrite, ex_MemRead, ex_MemWrite,
        input  ex_MemtoReg, ex_valid, load_use_hazard
    );

    // Stage side
    modport slave (
        input  hold, flush,
        input  id_valid, id_read_data_1, id_read_data_2, id_imm, id_shamt,
        input  id_rs, id_rt, id_rd, id_ALUOp, id_ALUSrc, id_RegDst,
        input  id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_uses_rt,
        input  exmem_RegWrite, exmem_rd, exmem_result,
        input  memwb_RegWrite, memwb_rd, memwb_result,
        output operando_1, operando_2, ALUOp, operation, ex_store_data,
        output ex_write_reg, ex_RegWrite, ex_MemRead, ex_MemWrite,
        output ex_MemtoReg, ex_valid, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// shift-amount operand selection and load-use hazard detection.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;

    // Latched instruction fields
    logic              r_valid;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [1:0]        r_ALUOp;
    logic              r_ALUSrc;
    logic              r_RegDst;
    logic              r_RegWrite;
    logic              r_MemRead;
    logic              r_MemWrite;
    logic              r_MemtoReg;

    // Combinational datapath
    logic              w_fwd_a_ex;
    logic              w_fwd_a_wb;
    logic              w_fwd_b_ex;
    logic              w_fwd_b_wb;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic              w_is_shift;
    logic [REG_W-1:0]  w_write_reg;
    logic              w_hazard_rs;
    logic              w_hazard_rt;

    // Pipeline register: reset > flush > hold > load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_ALUOp    <= '0;
            r_ALUSrc   <= 1'b0;
            r_RegDst   <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_MemtoReg <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: kill everything with side effects, keep data fields
            r_valid    <= 1'b0;
            r_ALUOp    <= '0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_MemtoReg <= 1'b0;
        end else if (!bus.hold) begin
            r_valid    <= bus.id_valid;
            r_rd1      <= bus.id_read_data_1;
            r_rd2      <= bus.id_read_data_2;
            r_imm      <= bus.id_imm;
            r_shamt    <= bus.id_shamt;
            r_rs       <= bus.id_rs;
            r_rt       <= bus.id_rt;
            r_rd       <= bus.id_rd;
            // An invalid ID slot enters EX as a bubble with no control asserted
            r_ALUOp    <= bus.id_valid ? bus.id_ALUOp : 2'b00;
            r_ALUSrc   <= bus.id_valid & bus.id_ALUSrc;
            r_RegDst   <= bus.id_valid & bus.id_RegDst;
            r_RegWrite <= bus.id_valid & bus.id_RegWrite;
            r_MemRead  <= bus.id_valid & bus.id_MemRead;
            r_MemWrite <= bus.id_valid & bus.id_MemWrite;
            r_MemtoReg <= bus.id_valid & bus.id_MemtoReg;
        end
    end

    // Forwarding match detection; register 0 is hardwired and never forwarded
    always_comb begin
        w_fwd_a_ex = bus.exmem_RegWrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs);
        w_fwd_b_ex = bus.exmem_RegWrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rt);
        w_fwd_a_wb = bus.memwb_RegWrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs);
        w_fwd_b_wb = bus.memwb_RegWrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rt);
    end

    // Forwarding muxes: EX/MEM is the younger result and wins over MEM/WB
    always_comb begin
        if (w_fwd_a_ex) begin
            w_fwd_a = bus.exmem_result;
        end else if (w_fwd_a_wb) begin
            w_fwd_a = bus.memwb_result;
        end else begin
            w_fwd_a = r_rd1;
        end

        if (w_fwd_b_ex) begin
            w_fwd_b = bus.exmem_result;
        end else if (w_fwd_b_wb) begin
            w_fwd_b = bus.memwb_result;
        end else begin
            w_fwd_b = r_rd2;
        end
    end

    // Operand selection: immediate shifts take shamt in place of rs
    always_comb begin
        w_is_shift = (r_ALUOp == ALUOP_RTYPE) &&
                     ((r_imm[5:0] == FUNCT_SLL) ||
                      (r_imm[5:0] == FUNCT_SRL) ||
                      (r_imm[5:0] == FUNCT_SRA));
        w_write_reg = r_RegDst ? r_rd : r_rt;

        bus.operando_1    = w_is_shift ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_a;
        bus.operando_2    = r_ALUSrc ? r_imm : w_fwd_b;
        bus.ex_store_data = w_fwd_b;
        bus.ex_write_reg  = w_write_reg;
        bus.ALUOp         = r_ALUOp;
        bus.operation     = r_imm[5:0];
        bus.ex_RegWrite   = r_RegWrite;
        bus.ex_MemRead    = r_MemRead;
        bus.ex_MemWrite   = r_MemWrite;
        bus.ex_MemtoReg   = r_MemtoReg;
        bus.ex_valid      = r_valid;
    end

    // Load-use detection against the instruction currently in ID
    always_comb begin
        w_hazard_rs = (w_write_reg == bus.id_rs);
        w_hazard_rt = bus.id_uses_rt && (w_write_reg == bus.id_rt);
        bus.load_use_hazard = r_valid && r_MemRead && (w_write_reg != '0) &&
                              (w_hazard_rs || w_hazard_rt);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus queues hand-computed expected
// outputs, a monitor pops and compares them on the falling edge.
module tb_id_ex_stage;

    logic clk;
    logic reset;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store;
        logic [1:0]  aluop;
        logic [5:0]  oper;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        v;
        logic        luh;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, field, act, expv);
        end
    endtask

    // Monitor: compare one expected entry per falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "operando_1",      bus.operando_1,      e.op1);
                chk(e.name, "operando_2",      bus.operando_2,      e.op2);
                chk(e.name, "ex_store_data",   bus.ex_store_data,   e.store);
                chk(e.name, "ALUOp",           32'(bus.ALUOp),      32'(e.aluop));
                chk(e.name, "operation",       32'(bus.operation),  32'(e.oper));
                chk(e.name, "ex_write_reg",    32'(bus.ex_write_reg), 32'(e.wreg));
                chk(e.name, "ex_RegWrite",     32'(bus.ex_RegWrite), 32'(e.rw));
                chk(e.name, "ex_MemRead",      32'(bus.ex_MemRead),  32'(e.mr));
                chk(e.name, "ex_MemWrite",     32'(bus.ex_MemWrite), 32'(e.mw));
                chk(e.name, "ex_MemtoReg",     32'(bus.ex_MemtoReg), 32'(e.m2r));
                chk(e.name, "ex_valid",        32'(bus.ex_valid),    32'(e.v));
                chk(e.name, "load_use_hazard", 32'(bus.load_use_hazard), 32'(e.luh));
            end
        end
    end

    task automatic expect_o(input string name, input logic [31:0] op1,
                            input logic [31:0] op2, input logic [31:0] store,
                            input logic [1:0] aluop, input logic [5:0] oper,
                            input logic [4:0] wreg, input logic rw, input logic mr,
                            input logic mw, input logic m2r, input logic v,
                            input logic luh);
        exp_t e;
        e.name = name; e.op1 = op1; e.op2 = op2; e.store = store;
        e.aluop = aluop; e.oper = oper; e.wreg = wreg; e.rw = rw; e.mr = mr;
        e.mw = mw; e.m2r = m2r; e.v = v; e.luh = luh;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input logic valid, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [4:0] shamt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [1:0] aluop, input logic alusrc,
                          input logic regdst, input logic rw, input logic mr,
                          input logic mw, input logic m2r, input logic uses_rt);
        bus.id_valid = valid;
        bus.id_read_data_1 = rd1;
        bus.id_read_data_2 = rd2;
        bus.id_imm = imm;
        bus.id_shamt = shamt;
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_rd = rd;
        bus.id_ALUOp = aluop;
        bus.id_ALUSrc = alusrc;
        bus.id_RegDst = regdst;
        bus.id_RegWrite = rw;
        bus.id_MemRead = mr;
        bus.id_MemWrite = mw;
        bus.id_MemtoReg = m2r;
        bus.id_uses_rt = uses_rt;
    endtask

    task automatic set_fwd(input logic ex_rw, input logic [4:0] ex_rd,
                           input logic [31:0] ex_res, input logic wb_rw,
                           input logic [4:0] wb_rd, input logic [31:0] wb_res);
        bus.exmem_RegWrite = ex_rw;
        bus.exmem_rd = ex_rd;
        bus.exmem_result = ex_res;
        bus.memwb_RegWrite = wb_rw;
        bus.memwb_rd = wb_rd;
        bus.memwb_result = wb_res;
    endtask

    // Advance past a rising edge / to just after the next falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        bus.hold = 1'b0;
        bus.flush = 1'b0;

        // Reset with random ID and forwarding inputs
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, $urandom(), $urandom(), $urandom(), 5'($urandom()),
                   5'($urandom()), 5'($urandom()), 5'($urandom()), 2'($urandom()),
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            set_fwd(1'b1, 5'($urandom()), $urandom(), 1'b1, 5'($urandom()), $urandom());
            step();
            expect_o("reset", '0, '0, '0, 2'b00, 6'h00, 5'd0, 0, 0, 0, 0, 0, 0);
            settle();
        end
        reset = 1'b0;

        // Invalid ID slot enters as a bubble, data fields still latched
        set_id(1'b0, 32'h5, 32'h6, 32'h9, 5'd0, 5'd1, 5'd2, 5'd7, 2'b10,
               1, 1, 1, 1, 1, 1, 1);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        expect_o("bubble_in", 32'h5, 32'h6, 32'h6, 2'b00, 6'h09, 5'd2, 0, 0, 0, 0, 0, 0);
        settle();

        // Plain ADD, no forwarding match
        set_id(1'b1, 32'hFFFF_FFFE, 32'h3, 32'h20, 5'd0, 5'd1, 5'd2, 5'd5, 2'b10,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(1, 5'd7, 32'hDEAD, 1, 5'd8, 32'hBEEF);
        step();
        expect_o("add", 32'hFFFF_FFFE, 32'h3, 32'h3, 2'b10, 6'h20, 5'd5, 1, 0, 0, 0, 1, 0);
        settle();

        // Forwarding priority on rs=rt=4
        set_id(1'b1, 32'hAAAA, 32'hBBBB, 32'h20, 5'd0, 5'd4, 5'd4, 5'd6, 2'b10,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        set_fwd(1, 5'd4, 32'h11, 1, 5'd4, 32'h22);
        expect_o("fwd_exmem", 32'h11, 32'h11, 32'h11, 2'b10, 6'h20, 5'd6, 1, 0, 0, 0, 1, 0);
        bus.hold = 1'b1;
        settle();
        step();
        set_fwd(0, 5'd4, 32'h11, 1, 5'd4, 32'h22);
        expect_o("fwd_memwb", 32'h22, 32'h22, 32'h22, 2'b10, 6'h20, 5'd6, 1, 0, 0, 0, 1, 0);
        settle();
        step();
        set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
        expect_o("fwd_r0", 32'hAAAA, 32'hBBBB, 32'hBBBB, 2'b10, 6'h20, 5'd6, 1, 0, 0, 0, 1, 0);
        bus.hold = 1'b0;
        settle();

        // SRA: shamt on operand A, forwarded rt on operand B
        set_id(1'b1, 32'h1234, 32'h0, 32'h3, 5'd5, 5'd9, 5'd10, 5'd11, 2'b10,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        set_fwd(0, 5'd0, 32'h0, 1, 5'd10, 32'h8000_0000);
        expect_o("sra", 32'h5, 32'h8000_0000, 32'h8000_0000, 2'b10, 6'h03, 5'd11,
                 1, 0, 0, 0, 1, 0);
        settle();

        // LW writing r3, ID reads r3 as rs
        set_id(1'b1, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd3, 5'd3, 2'b00,
               1, 0, 1, 1, 0, 1, 1);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        set_fwd(1, 5'd3, 32'h77, 0, 5'd0, 32'h0);
        bus.id_rs = 5'd3;
        expect_o("lw_luh", 32'h100, 32'hFFFF_FFFC, 32'h77, 2'b00, 6'h3C, 5'd3,
                 1, 1, 0, 1, 1, 1);
        bus.flush = 1'b1;
        settle();
        step();
        bus.flush = 1'b0;
        expect_o("flush", 32'h100, 32'hFFFF_FFFC, 32'h77, 2'b00, 6'h3C, 5'd3,
                 0, 0, 0, 0, 0, 0);
        settle();

        // Reload LW; ID reads rt=3 but does not use it, then does
        set_id(1'b1, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd3, 5'd3, 2'b00,
               1, 0, 1, 1, 0, 1, 1);
        step();
        bus.id_uses_rt = 1'b0;
        expect_o("rt_unused", 32'h100, 32'hFFFF_FFFC, 32'h77, 2'b00, 6'h3C, 5'd3,
                 1, 1, 0, 1, 1, 0);
        bus.hold = 1'b1;
        settle();
        step();
        bus.id_uses_rt = 1'b1;
        expect_o("rt_used", 32'h100, 32'hFFFF_FFFC, 32'h77, 2'b00, 6'h3C, 5'd3,
                 1, 1, 0, 1, 1, 1);
        bus.hold = 1'b0;
        settle();

        // Hold for 3 cycles while ID presents something else
        set_id(1'b1, 32'hFFFF_FFFE, 32'h3, 32'h20, 5'd0, 5'd1, 5'd2, 5'd5, 2'b10,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        expect_o("pre_hold", 32'hFFFF_FFFE, 32'h3, 32'h3, 2'b10, 6'h20, 5'd5, 1, 0, 0, 0, 1, 0);
        bus.hold = 1'b1;
        set_id(1'b1, 32'h123, 32'h456, 32'hFFFF_FFFF, 5'd7, 5'd8, 5'd9, 5'd10, 2'b01,
               1, 0, 0, 1, 1, 1, 1);
        settle();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_o("hold", 32'hFFFF_FFFE, 32'h3, 32'h3, 2'b10, 6'h20, 5'd5, 1, 0, 0, 0, 1, 0);
            if (i == 2) bus.flush = 1'b1;
            settle();
        end

        // hold + flush: flush wins
        step();
        expect_o("hold_flush", 32'hFFFF_FFFE, 32'h3, 32'h3, 2'b00, 6'h20, 5'd5, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b0;
        reset = 1'b1;
        settle();

        // reset + hold: reset wins
        step();
        expect_o("reset_hold", '0, '0, '0, 2'b00, 6'h00, 5'd0, 0, 0, 0, 0, 0, 0);
        settle();
        reset = 1'b0;
        bus.hold = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
